ps2_scan_receiver: RTL and testbench
====================================

Name: ps2_scan_receiver

Overview:
Host-side PS/2 receiver. Samples the ps2_clk/ps2_dat pair driven by a keyboard (device) model, deframes 11-bit frames (start, d0..d7 LSB first, odd parity, stop) and validates each frame. Each good scan_code byte is pushed into a small first-word-fall-through FIFO. Sits between the PS/2 pins and the key-decode/raster control logic.

Parameters:
FIFO_DEPTH, 8, scan_code FIFO entries; power of 2, >= 2.
TIMEOUT_CYCLES, 1024, Clock cycles with no ps2_clk falling edge mid-frame before the frame is aborted.

Ports:
Clock  input  1  system clock; ps2_clk runs >= 6x slower.
Resetn  input  1  asynchronous, active-low reset.
ps2_clk  input  1  PS/2 clock from device, asynchronous to Clock.
ps2_dat  input  1  PS/2 data from device, asynchronous to Clock.
rd_data  output  8  oldest scan_code in FIFO; valid when rd_valid = 1.
rd_valid  output  1  FIFO not empty.
rd_ready  input  1  consumer accepts rd_data; pop occurs when rd_valid && rd_ready.
parity_err  output  1  1-cycle pulse: frame discarded, parity not odd.
framing_err  output  1  1-cycle pulse: frame discarded, bad stop bit or timeout.
overflow  output  1  1-cycle pulse: good frame dropped, FIFO full.

Behaviour:
- Reset (async assert, sync release): FSM = IDLE; bit count, shift register, timeout counter and FIFO pointers = 0. rd_valid, parity_err, framing_err and overflow = 0. rd_data = 8'h00.
- Input path: ps2_clk and ps2_dat each pass through a 2-FF synchronizer. A falling edge is a synced clk of 1 then 0 on consecutive cycles. Data is sampled from synced ps2_dat in the cycle the edge is detected.
- FSM IDLE:
  - Edge with data = 0 (start bit) -> RECV; bit count = 1; timeout counter cleared.
  - Edge with data = 1 -> stay IDLE; no error.
- FSM RECV:
  - Each edge shifts the data bit in (bits 1..8 fill d0..d7 LSB first; bit 9 = parity); bit count increments; timeout counter cleared.
  - Edge 10 (stop) -> CHECK. Stop and parity results are registered that cycle.
  - Timeout counter reaching TIMEOUT_CYCLES-1 -> IDLE with a framing_err pulse. Partial data is discarded.
- FSM CHECK (one cycle, then always IDLE). Priority order:
  - stop = 0 -> framing_err.
  - Else XOR(d7..d0, parity) = 0 -> parity_err.
  - Else if FIFO full and no pop this cycle -> overflow; byte dropped.
  - Else push the byte.
- Latency: the push lands at the end of the CHECK cycle; rd_valid rises 2 cycles after the stop-bit edge is detected.
- FIFO: first-word fall-through; rd_data shows the head entry combinationally from the registered array. Push and pop in the same cycle are both honoured, including when full or holding one entry.
  - Pop while empty is ignored.
  - Pointers wrap modulo FIFO_DEPTH.
  - A count register of width $clog2(FIFO_DEPTH)+1 distinguishes full from empty.
- Timeout counter width: $clog2(TIMEOUT_CYCLES). It saturates and runs only in RECV.
- Reset mid-frame discards the partial frame and all FIFO contents.

Optional Feature:
PS2_RX_GLITCH_FILTER_EN:
- Defined: synced ps2_clk feeds a 2-cycle stability filter. The filtered level changes only after 2 consecutive equal samples, and edge detection uses the filtered level. This adds 2 cycles to every latency above; data is sampled in the same cycle as the filtered edge.
- Undefined: no filter; the edge is detected directly from the synchronizer output.

Decomposition:
- Package ps2_pkg:
  - Frame constants: PS2_FRAME_BITS = 11, PS2_START = 1'b0, PS2_STOP = 1'b1.
  - FSM state enum {IDLE, RECV, CHECK}.
  - Scan-code constant PS2_BREAK = 8'hF0, shared with the keyboard model and bench.
- One sub-module: ps2_rx_fifo (parameterized FWFT FIFO with push, pop, full and count).

Test Plan:
1. Frame 0x1C, parity 0, stop 1 -> rd_valid rises 2 cycles after the stop edge; rd_data = 8'h1C; no error pulses.
2. Back-to-back 0xF0 (parity 1) then 0x1C with rd_ready = 0 -> FIFO holds F0 then 1C. Pop twice with rd_ready = 1 -> reads 8'hF0 then 8'h1C; rd_valid = 0 after.
3. 0x1C sent with parity 1 -> one parity_err pulse; rd_valid stays 0. Next frame 0x29 (parity 0) -> rd_data = 8'h29.
4. Stop bit 0 on 0x1C -> framing_err pulse, nothing pushed. Separately, 5 bits then ps2_clk held high -> framing_err exactly TIMEOUT_CYCLES cycles after the last edge; a following 0x29 frame is received correctly.
5. FIFO_DEPTH = 8: nine frames 0x01..0x09 with no pops -> overflow pulse on frame 9; drain reads 0x01..0x08. Repeat with a pop asserted in frame 9's CHECK cycle -> no overflow; 0x09 is stored.
6. Resetn pulsed low after 6 bits of 0x1C with 2 bytes queued -> all outputs 0 immediately, FIFO empty; a subsequent 0x5A frame (parity 1) is received correctly.

Source files
------------

// File: rtl/ps2_pkg.sv
// Shared PS/2 constants: frame layout, receiver FSM states and the break
// scan-code prefix used by the keyboard model and the bench.
package ps2_pkg;

    localparam int       PS2_FRAME_BITS = 11;
    localparam logic     PS2_START      = 1'b0;
    localparam logic     PS2_STOP       = 1'b1;
    localparam logic [7:0] PS2_BREAK    = 8'hF0;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RECV  = 2'd1,
        CHECK = 2'd2
    } ps2_state_e;

endpackage

// File: rtl/ps2_rx_fifo.sv
// First-word-fall-through FIFO for received scan codes. The head entry is
// presented combinationally; push and pop in one cycle are both honoured,
// including when full. rd_data reads as zero while empty.
module ps2_rx_fifo #(
    parameter int DEPTH = 8,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             push_data,
    input  logic                     pop,
    output logic [W-1:0]             rd_data,
    output logic                     full,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic [W-1:0]  mem_q [DEPTH];
    logic [W-1:0]  mem_d [DEPTH];
    logic          empty;
    logic          do_push;
    logic          do_pop;

    assign empty   = (count_q == '0);
    assign full    = (count_q == CW'(DEPTH));
    assign do_pop  = pop & ~empty;
    assign do_push = push & (~full | do_pop);
    assign count   = count_q;
    assign rd_data = empty ? '0 : mem_q[rd_ptr_q];

    // Next-state for pointers, occupancy and storage array
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q + {{AW{1'b0}}, do_push} - {{AW{1'b0}}, do_pop};
        mem_d    = mem_q;
        if (do_push) begin
            mem_d[wr_ptr_q] = push_data;
            wr_ptr_d        = wr_ptr_q + 1'b1;
        end
        if (do_pop) begin
            rd_ptr_d = rd_ptr_q + 1'b1;
        end
    end

    // Pointer and count registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Storage array; contents are only visible through count, so no reset
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

endmodule

// File: rtl/ps2_scan_receiver.sv
// Host-side PS/2 receiver: synchronizes ps2_clk/ps2_dat, deframes 11-bit
// frames on falling edges, validates stop and odd parity, and queues good
// bytes into an FWFT FIFO.
// Optional macro PS2_RX_GLITCH_FILTER_EN adds a 2-sample stability filter on
// the synchronized ps2_clk (adds 2 cycles to every latency).
module ps2_scan_receiver
    import ps2_pkg::*;
#(
    parameter int FIFO_DEPTH     = 8,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic       Clock,
    input  logic       Resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    input  logic       rd_ready,
    output logic       parity_err,
    output logic       framing_err,
    output logic       overflow
);
    localparam int              TW      = $clog2(TIMEOUT_CYCLES);
    localparam int              CW      = $clog2(FIFO_DEPTH) + 1;
    localparam logic [TW-1:0]   TO_LAST = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [3:0]      STOP_IX = 4'(PS2_FRAME_BITS - 1);

    logic clk_s1_q, clk_s2_q, dat_s1_q, dat_s2_q, clk_prev_q;
    logic clk_lvl;
    logic fall;

    ps2_state_e    state_q, state_d;
    logic [3:0]    bit_cnt_q, bit_cnt_d;
    logic [7:0]    shift_q, shift_d;
    logic          parity_q, parity_d;
    logic          stop_ok_q, stop_ok_d;
    logic          par_ok_q, par_ok_d;
    logic [TW-1:0] tmo_q, tmo_d;
    logic          tmo_hit;

    logic          in_check, good, full, pop, push;
    logic [CW-1:0] count;

    // Two-flop synchronizers; idle line level is high
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            clk_s1_q   <= 1'b1;
            clk_s2_q   <= 1'b1;
            dat_s1_q   <= 1'b1;
            dat_s2_q   <= 1'b1;
            clk_prev_q <= 1'b1;
        end else begin
            clk_s1_q   <= ps2_clk;
            clk_s2_q   <= clk_s1_q;
            dat_s1_q   <= ps2_dat;
            dat_s2_q   <= dat_s1_q;
            clk_prev_q <= clk_lvl;
        end
    end

`ifdef PS2_RX_GLITCH_FILTER_EN
    logic clk_s3_q;
    logic clk_filt_q, clk_filt_d;

    // Filtered level follows the synced clock only after two equal samples
    always_comb begin
        clk_filt_d = (clk_s2_q == clk_s3_q) ? clk_s2_q : clk_filt_q;
    end

    // Filter history and filtered level registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            clk_s3_q   <= 1'b1;
            clk_filt_q <= 1'b1;
        end else begin
            clk_s3_q   <= clk_s2_q;
            clk_filt_q <= clk_filt_d;
        end
    end

    assign clk_lvl = clk_filt_q;
`else
    assign clk_lvl = clk_s2_q;
`endif

    assign fall = clk_prev_q & ~clk_lvl;

    // Frame FSM: start detection, bit shifting, timeout and stop capture
    always_comb begin
        state_d   = state_q;
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        parity_d  = parity_q;
        stop_ok_d = stop_ok_q;
        par_ok_d  = par_ok_q;
        tmo_d     = tmo_q;
        tmo_hit   = 1'b0;
        case (state_q)
            IDLE: begin
                tmo_d = '0;
                if (fall && (dat_s2_q == PS2_START)) begin
                    state_d   = RECV;
                    bit_cnt_d = 4'd1;
                end
            end
            RECV: begin
                if (fall) begin
                    tmo_d     = '0;
                    bit_cnt_d = bit_cnt_q + 4'd1;
                    if (bit_cnt_q <= 4'd8) begin
                        shift_d = {dat_s2_q, shift_q[7:1]};
                    end else if (bit_cnt_q < STOP_IX) begin
                        parity_d = dat_s2_q;
                    end else begin
                        stop_ok_d = (dat_s2_q == PS2_STOP);
                        par_ok_d  = ^{shift_q, parity_q};
                        state_d   = CHECK;
                    end
                end else if (tmo_q == TO_LAST) begin
                    tmo_hit   = 1'b1;
                    tmo_d     = '0;
                    bit_cnt_d = '0;
                    state_d   = IDLE;
                end else begin
                    tmo_d = tmo_q + 1'b1;
                end
            end
            CHECK: begin
                bit_cnt_d = '0;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Frame FSM registers
    always_ff @(posedge Clock or negedge Resetn) begin
        if (!Resetn) begin
            state_q   <= IDLE;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            parity_q  <= 1'b0;
            stop_ok_q <= 1'b0;
            par_ok_q  <= 1'b0;
            tmo_q     <= '0;
        end else begin
            state_q   <= state_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            parity_q  <= parity_d;
            stop_ok_q <= stop_ok_d;
            par_ok_q  <= par_ok_d;
            tmo_q     <= tmo_d;
        end
    end

    // Frame verdict in the CHECK cycle; stop error outranks parity error
    assign in_check    = (state_q == CHECK);
    assign good        = in_check & stop_ok_q & par_ok_q;
    assign framing_err = (in_check & ~stop_ok_q) | tmo_hit;
    assign parity_err  = in_check & stop_ok_q & ~par_ok_q;
    assign pop         = rd_valid & rd_ready;
    assign overflow    = good & full & ~pop;
    assign push        = good & ~overflow;
    assign rd_valid    = (count != '0);

    ps2_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk       (Clock),
        .rst_n     (Resetn),
        .push      (push),
        .push_data (shift_q),
        .pop       (pop),
        .rd_data   (rd_data),
        .full      (full),
        .count     (count)
    );

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: a table of single frames plus
// hand-written sequences for queueing, timeout, overflow and reset.
module tb_ps2_scan_receiver;
    import ps2_pkg::*;

    localparam int DEPTH = 8;
    localparam int TMO   = 64;
    localparam int HALF  = 6;
`ifdef PS2_RX_GLITCH_FILTER_EN
    localparam int EDGE_LAT = 4;
`else
    localparam int EDGE_LAT = 2;
`endif

    logic       Clock = 1'b0;
    logic       Resetn = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic       parity_err, framing_err, overflow;

    ps2_scan_receiver #(
        .FIFO_DEPTH     (DEPTH),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .Clock       (Clock),
        .Resetn      (Resetn),
        .ps2_clk     (ps2_clk),
        .ps2_dat     (ps2_dat),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .parity_err  (parity_err),
        .framing_err (framing_err),
        .overflow    (overflow)
    );

    always #5 Clock = ~Clock;

    int checks = 0;
    int failures = 0;
    int n_perr = 0, n_ferr = 0, n_ovf = 0;
    int w_valid, w_ferr;

    typedef struct {
        logic [7:0] data;
        logic       par;
        logic       stop;
        logic       exp_push;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[9];

    // Running tally of error pulses
    always @(negedge Clock) begin
        if (Resetn) begin
            if (parity_err)  n_perr++;
            if (framing_err) n_ferr++;
            if (overflow)    n_ovf++;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s actual=%0d (0x%0h) required=%0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge Clock);
        #1;
    endtask

    // Drive the first n bits; returns just after driving the nth falling edge
    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = bits[i];
            tick(HALF);
            ps2_clk = 1'b0;
            if (i != n - 1) begin
                tick(HALF);
                ps2_clk = 1'b1;
            end
        end
    endtask

    function automatic logic [10:0] frame(input logic [7:0] d, input logic p, input logic s);
        return {s, p, d, 1'b0};
    endfunction

    task automatic watch(input int ncyc);
        w_valid = -1;
        w_ferr  = -1;
        for (int i = 0; i < ncyc; i++) begin
            @(negedge Clock);
            if (rd_valid && w_valid < 0) w_valid = i;
            if (framing_err && w_ferr < 0) w_ferr = i;
        end
    endtask

    task automatic release_line();
        @(posedge Clock);
        #1;
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        tick(HALF);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s);
        send_bits(frame(d, p, s), 11);
        watch(EDGE_LAT + 4);
        release_line();
    endtask

    task automatic pop_one();
        rd_ready = 1'b1;
        tick(1);
        rd_ready = 1'b0;
    endtask

    task automatic expect_head(input string name, input logic [7:0] exp);
        @(negedge Clock);
        check({name, ".valid"}, int'(rd_valid), 1);
        check({name, ".data"}, int'(rd_data), int'(exp));
        tick(0);
        pop_one();
    endtask

    task automatic expect_empty(input string name);
        @(negedge Clock);
        check(name, int'(rd_valid), 0);
        tick(0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int p0, f0, o0;
        vecs[0] = '{8'h1C, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[1] = '{8'h1C, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
        vecs[2] = '{8'h29, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{8'h1C, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        vecs[4] = '{8'h5A, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[5] = '{8'h00, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[7] = '{8'h80, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        vecs[8] = '{8'h1C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};

        // Reset state
        tick(3);
        Resetn = 1'b1;
        tick(2);
        @(negedge Clock);
        check("reset.rd_valid", int'(rd_valid), 0);
        check("reset.rd_data", int'(rd_data), 0);
        check("reset.errs", int'({parity_err, framing_err, overflow}), 0);
        tick(0);

        // Single-frame table
        for (int v = 0; v < 9; v++) begin
            p0 = n_perr; f0 = n_ferr; o0 = n_ovf;
            send_frame(vecs[v].data, vecs[v].par, vecs[v].stop);
            check($sformatf("vec%0d.perr", v), n_perr - p0, int'(vecs[v].exp_perr));
            check($sformatf("vec%0d.ferr", v), n_ferr - f0, int'(vecs[v].exp_ferr));
            check($sformatf("vec%0d.ovf", v), n_ovf - o0, 0);
            if (vecs[v].exp_push) begin
                check($sformatf("vec%0d.latency", v), w_valid, EDGE_LAT + 2);
                expect_head($sformatf("vec%0d", v), vecs[v].data);
            end else begin
                check($sformatf("vec%0d.nopush", v), w_valid, -1);
            end
            expect_empty($sformatf("vec%0d.empty", v));
        end

        // Back-to-back frames queue in order
        send_frame(PS2_BREAK, 1'b1, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        expect_head("b2b.first", PS2_BREAK);
        expect_head("b2b.second", 8'h1C);
        expect_empty("b2b.empty");

        // Timeout after 5 bits, then a clean frame
        f0 = n_ferr;
        send_bits(frame(8'h1C, 1'b0, 1'b1), 5);
        fork
            watch(EDGE_LAT + TMO + 10);
            begin
                tick(HALF);
                ps2_clk = 1'b1;
                ps2_dat = 1'b1;
            end
        join
        check("tmo.cycle", w_ferr, EDGE_LAT + TMO);
        check("tmo.count", n_ferr - f0, 1);
        check("tmo.nopush", int'(rd_valid), 0);
        tick(HALF);
        send_frame(8'h29, 1'b0, 1'b1);
        expect_head("tmo.next", 8'h29);
        expect_empty("tmo.empty");

        // Overflow on the ninth frame with no pops
        o0 = n_ovf;
        for (int k = 1; k <= 8; k++) send_frame(8'(k), ~^8'(k), 1'b1);
        check("ovf.none_before", n_ovf - o0, 0);
        send_frame(8'h09, ~^8'h09, 1'b1);
        check("ovf.pulse", n_ovf - o0, 1);
        for (int k = 1; k <= 8; k++) expect_head($sformatf("ovf.drain%0d", k), 8'(k));
        expect_empty("ovf.empty");

        // Pop during the ninth frame's CHECK cycle avoids the overflow
        o0 = n_ovf;
        for (int k = 1; k <= 8; k++) send_frame(8'(k), ~^8'(k), 1'b1);
        send_bits(frame(8'h09, ~^8'h09, 1'b1), 11);
        fork
            watch(EDGE_LAT + 4);
            begin
                tick(EDGE_LAT + 1);
                rd_ready = 1'b1;
                tick(1);
                rd_ready = 1'b0;
            end
        join
        release_line();
        check("ovfpop.none", n_ovf - o0, 0);
        for (int k = 2; k <= 9; k++) expect_head($sformatf("ovfpop.drain%0d", k), 8'(k));
        expect_empty("ovfpop.empty");

        // Reset mid-frame with two bytes queued
        send_frame(8'h11, ~^8'h11, 1'b1);
        send_frame(8'h22, ~^8'h22, 1'b1);
        send_bits(frame(8'h1C, 1'b0, 1'b1), 6);
        tick(1);
        Resetn = 1'b0;
        #1;
        check("rst.rd_valid", int'(rd_valid), 0);
        check("rst.rd_data", int'(rd_data), 0);
        check("rst.errs", int'({parity_err, framing_err, overflow}), 0);
        tick(2);
        ps2_clk = 1'b1;
        ps2_dat = 1'b1;
        Resetn = 1'b1;
        tick(HALF);
        expect_empty("rst.empty");
        p0 = n_perr; f0 = n_ferr;
        send_frame(8'h5A, 1'b1, 1'b1);
        check("rst.next_errs", (n_perr - p0) + (n_ferr - f0), 0);
        expect_head("rst.next", 8'h5A);
        expect_empty("rst.final_empty");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
